// File: rtl/scaler_v.sv
// ---------------------------------------------------------------------------
// scaler_v : vertical downscaler for the de/hs/vs pixel stream from scaler_h.
//
// Each output line is a linear blend of the previous input line (held in a
// block-RAM line buffer) and the current input line. Output line k sits at
// vertical position k*step (4.12 fixed point, step clamped to >= 1.0). So at
// most one output line is produced per input line, and the output runs at the
// input rate with a fixed 3-clock pipeline.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   scale_step    4.12 input lines per output line, taken at frame start
//   di_i/de_i     input pixel / pixel valid
//   hs_i/vs_i     input line-active / frame-active
//   do_o/de_o     output pixel / pixel valid (do_o is 0 while de_o is 0)
//   hs_o          output line-active, only for emitted lines
//   vs_o          frame-active, vs_i delayed 3 clocks
//   dbg_state_o   FSM state (0 = IDLE, 1 = FRAME)
//
// Handshake: there is no backpressure. A pixel is accepted in every cycle
// where de_i and hs_i are both high inside an active frame. The matching
// output pixel appears exactly 3 clocks later with de_o high. That holds only
// when the line is emitted and the pixel index is below LINE_SIZE_MAX.
// ---------------------------------------------------------------------------
module scaler_v #(
    parameter int LINE_SIZE_MAX = 4096,
    parameter int DATA_WIDTH    = 8,
    parameter int PIXEL_STEP    = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           scale_step,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  dbg_state_o
);

    localparam int XW = $clog2(LINE_SIZE_MAX + 1);
    localparam int AW = $clog2(LINE_SIZE_MAX);
    localparam int SW = DATA_WIDTH + 13;

    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_FRAME  = 1'b1;
    localparam logic [15:0]   STEP_MIN = 16'(PIXEL_STEP);
    localparam logic [12:0]   ONE      = 13'(PIXEL_STEP);
    localparam logic [XW-1:0] X_LIMIT  = XW'(LINE_SIZE_MAX);

    // control state
    logic [0:0]    r_state;
    logic          r_vs_prev;
    logic          r_hs_prev;
    logic [15:0]   r_step;
    logic [15:0]   r_n;
    logic [27:0]   r_pos;
    logic [XW-1:0] r_x;

    // line buffer
    logic [DATA_WIDTH-1:0] r_mem [LINE_SIZE_MAX];
    logic [DATA_WIDTH-1:0] r_rd;

    // pipeline
    logic                  r1_de, r1_hs, r1_vs;
    logic [DATA_WIDTH-1:0] r1_cur;
    logic [11:0]           r1_frac;
    logic                  r2_de, r2_hs, r2_vs, r2_fz;
    logic [DATA_WIDTH-1:0] r2_cur;
    logic [DATA_WIDTH-1:0] r2_mix;

    logic          w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall;
    logic          w_in_frame;
    logic [15:0]   w_step_clamp, w_step_eff, w_n_eff, w_n_inc;
    logic [27:0]   w_pos_eff, w_pos_next;
    logic [28:0]   w_pos_sum;
    logic [15:0]   w_int;
    logic [11:0]   w_frac;
    logic          w_emit;
    logic [XW-1:0] w_x_eff;
    logic          w_x_ok;
    logic          w_pix;
    logic [AW-1:0] w_addr;
    logic [12:0]   w_wprev;
    logic [SW-1:0] w_sum;

    assign w_vs_rise = vs_i & ~r_vs_prev;
    assign w_vs_fall = ~vs_i & r_vs_prev;
    assign w_hs_rise = hs_i & ~r_hs_prev;
    assign w_hs_fall = ~hs_i & r_hs_prev;

    // The rising-edge cycle already belongs to the frame, so it is included
    // here even though the state register only flips on the following edge.
    assign w_in_frame = vs_i & ((r_state == S_FRAME) | w_vs_rise);

    assign w_step_clamp = (scale_step < STEP_MIN) ? STEP_MIN : scale_step;

    // The frame-start values apply in the rising-edge cycle itself.
    assign w_step_eff = w_vs_rise ? w_step_clamp : r_step;
    assign w_n_eff    = w_vs_rise ? 16'd0 : r_n;
    assign w_pos_eff  = w_vs_rise ? 28'd0 : r_pos;
    assign w_n_inc    = (w_n_eff == 16'hFFFF) ? w_n_eff : w_n_eff + 16'd1;

    assign w_pos_sum  = {1'b0, w_pos_eff} + 29'(w_step_eff);
    assign w_pos_next = w_pos_sum[28] ? 28'hFFF_FFFF : w_pos_sum[27:0];

    assign w_int  = w_pos_eff[27:12];
    assign w_frac = w_pos_eff[11:0];

    // An integer position is taken from the current line. A fractional
    // position between lines n-1 and n is produced while line n streams in.
    assign w_emit = w_in_frame &
                    (((w_frac == 12'd0) && (w_int == w_n_eff)) ||
                     ((w_frac != 12'd0) && (w_n_eff != 16'd0) &&
                      (w_int == w_n_eff - 16'd1)));

    // A pixel in the same cycle as the hs_i rising edge is pixel 0.
    assign w_x_eff = w_hs_rise ? '0 : r_x;
    assign w_x_ok  = (w_x_eff < X_LIMIT);
    assign w_pix   = de_i & hs_i & w_in_frame & w_x_ok;
    assign w_addr  = w_x_eff[AW-1:0];

    // FSM and line/position/pixel counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            // Track vs_i/hs_i through reset so a frame already in progress
            // is not mistaken for a new one when reset is released.
            r_vs_prev <= vs_i;
            r_hs_prev <= hs_i;
            r_step    <= STEP_MIN;
            r_n       <= 16'd0;
            r_pos     <= 28'd0;
            r_x       <= '0;
        end else begin
            r_vs_prev <= vs_i;
            r_hs_prev <= hs_i;
            case (r_state)
                S_IDLE:  if (w_vs_rise) r_state <= S_FRAME;
                S_FRAME: if (w_vs_fall) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_in_frame) begin
                r_step <= w_step_eff;
                r_n    <= w_hs_fall ? w_n_inc : w_n_eff;
                r_pos  <= (w_hs_fall && w_emit) ? w_pos_next : w_pos_eff;
                if (de_i && hs_i && w_x_ok)
                    r_x <= w_x_eff + XW'(1);
                else
                    r_x <= w_x_eff;
            end
        end
    end

    // Line buffer. Read-before-write: the read returns the previous line's
    // pixel at this x while the current pixel replaces it.
    always_ff @(posedge clk) begin
        r_rd <= r_mem[w_addr];
        if (w_pix)
            r_mem[w_addr] <= di_i;
    end

    // Blend: prev*(1-f) + cur*f, rounded to nearest.
    assign w_wprev = ONE - {1'b0, r1_frac};
    assign w_sum   = SW'(r_rd) * SW'(w_wprev) + SW'(r1_cur) * SW'(r1_frac) + SW'(2048);

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_de   <= 1'b0;
            r1_hs   <= 1'b0;
            r1_vs   <= 1'b0;
            r1_cur  <= '0;
            r1_frac <= 12'd0;
            r2_de   <= 1'b0;
            r2_hs   <= 1'b0;
            r2_vs   <= 1'b0;
            r2_fz   <= 1'b0;
            r2_cur  <= '0;
            r2_mix  <= '0;
            de_o    <= 1'b0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
            do_o    <= '0;
        end else begin
            r1_de   <= w_pix & w_emit;
            r1_hs   <= hs_i & w_emit;
            r1_vs   <= w_in_frame;
            r1_cur  <= di_i;
            r1_frac <= w_frac;

            r2_de   <= r1_de;
            r2_hs   <= r1_hs;
            r2_vs   <= r1_vs;
            r2_fz   <= (r1_frac == 12'd0);
            r2_cur  <= r1_cur;
            r2_mix  <= DATA_WIDTH'(w_sum >> 12);

            de_o    <= r2_de;
            hs_o    <= r2_hs;
            vs_o    <= r2_vs;
            if (!r2_de)
                do_o <= '0;
            else if (r2_fz)
                do_o <= r2_cur;
            else
                do_o <= r2_mix;
        end
    end

    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_scaler_v.sv
module tb_scaler_v;
  localparam int LSM   = 4096;
  localparam int MAXW  = LSM + 2;
  localparam int NRAND = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [15:0] scale_step = 16'd4096;
  logic [7:0] di_i = 8'd0;
  logic       de_i = 1'b0;
  logic       hs_i = 1'b0;
  logic       vs_i = 1'b0;
  logic [7:0] do_o;
  logic       de_o, hs_o, vs_o, dbg_state_o;

  scaler_v #(.LINE_SIZE_MAX(LSM), .DATA_WIDTH(8), .PIXEL_STEP(4096)) dut (
    .clk(clk), .rst(rst), .scale_step(scale_step),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- frame description and reference model ----------------
  logic [7:0] pix [0:7][0:MAXW-1];
  int nl, wd, per, step_in, mid_step;
  bit emit_ln [0:7];
  logic [7:0] exp_q[$];
  int exp_lines_q[$];
  int in_cyc_q[$];
  int hs_rise_q[$];
  int vs_rise_in;
  int rst_cyc;
  bit rst_win = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  // ---------------- monitor (samples on the falling edge) ----------------
  logic [7:0] obs_val_q[$];
  int obs_cyc_q[$];
  int obs_hs_q[$];
  int vs_rise_out = -1;
  int nz_bad = 0;
  int post_rst_bad = 0;
  logic hs_o_q = 1'b0;
  logic vs_o_q = 1'b0;

  always @(negedge clk) begin
    if (de_o) begin
      obs_val_q.push_back(do_o);
      obs_cyc_q.push_back(cyc);
    end
    if (!de_o && do_o != 8'd0) nz_bad <= nz_bad + 1;
    if (hs_o && !hs_o_q) obs_hs_q.push_back(cyc);
    if (vs_o && !vs_o_q) vs_rise_out <= cyc;
    if (rst_win && (de_o || hs_o || vs_o || do_o != 8'd0)) post_rst_bad <= post_rst_bad + 1;
    hs_o_q <= hs_o;
    vs_o_q <= vs_o;
  end

  // Output line k sits at k*step input lines: integer positions copy that
  // line, fractional ones blend line I and I+1. Positions whose source lines
  // do not exist in the frame are dropped.
  function automatic void build_model();
    int st, wv, p, li, f, a, b, src;
    exp_q.delete();
    exp_lines_q.delete();
    for (int l = 0; l < 8; l++) emit_ln[l] = 1'b0;
    st = (step_in < 4096) ? 4096 : step_in;
    wv = (wd < LSM) ? wd : LSM;
    for (int k = 0; k < 64; k++) begin
      p  = k * st;
      li = p / 4096;
      f  = p % 4096;
      if (f == 0) begin
        if (li >= nl) break;
        src = li;
      end else begin
        if (li + 1 >= nl) break;
        src = li + 1;
      end
      emit_ln[src] = 1'b1;
      exp_lines_q.push_back(src);
      for (int x = 0; x < wv; x++) begin
        if (f == 0) begin
          exp_q.push_back(pix[li][x]);
        end else begin
          a = int'(pix[li][x]);
          b = int'(pix[li + 1][x]);
          exp_q.push_back(8'((a * (4096 - f) + b * f + 2048) / 4096));
        end
      end
    end
  endfunction

  function automatic void setup(input int id);
    per = 1;
    mid_step = -1;
    case (id)
      0, 1: begin
        nl = 4; wd = 8; step_in = (id == 0) ? 4096 : 2048;
        for (int l = 0; l < nl; l++) for (int x = 0; x < wd; x++) pix[l][x] = 8'(10 * (l + 1));
      end
      2, 5, 6: begin
        nl = 6; wd = 8; step_in = 6144;
        per = (id == 5) ? 2 : ((id == 6) ? 4 : 1);
        for (int l = 0; l < nl; l++) for (int x = 0; x < wd; x++) pix[l][x] = 8'(30 * l);
      end
      3: begin
        nl = 3; wd = 8; step_in = 5120;
        for (int x = 0; x < wd; x++) begin
          pix[0][x] = 8'd0; pix[1][x] = 8'd0; pix[2][x] = 8'd255;
        end
      end
      4: begin
        nl = 5; wd = 8; step_in = 8192;
        for (int l = 0; l < nl; l++) for (int x = 0; x < wd; x++) pix[l][x] = 8'($urandom_range(0, 255));
      end
      7: begin
        nl = 1; wd = LSM + 2; step_in = 4096;
        for (int x = 0; x < wd; x++) pix[0][x] = 8'($urandom_range(0, 255));
      end
      default: begin
        nl = $urandom_range(2, 8);
        wd = $urandom_range(1, 12);
        per = $urandom_range(1, 3);
        step_in = $urandom_range(2000, 14000);
        mid_step = $urandom_range(0, 1) ? $urandom_range(4096, 9000) : -1;
        for (int l = 0; l < nl; l++) for (int x = 0; x < wd; x++) pix[l][x] = 8'($urandom_range(0, 255));
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame. Emitted-line pixels and hs_i rises are logged with the
  // cycle in which the DUT samples them (minus one). rst_line >= 0 pulses rst
  // in the middle of that line.
  task automatic drive_frame(input int rst_line);
    scale_step = 16'(step_in);
    tick();
    vs_i = 1'b1;
    vs_rise_in = cyc;
    tick();
    tick();
    for (int l = 0; l < nl; l++) begin
      hs_i = 1'b1;
      if (emit_ln[l]) hs_rise_q.push_back(cyc);
      for (int p = 0; p < wd; p++) begin
        di_i = pix[l][p];
        de_i = 1'b1;
        if (emit_ln[l] && p < LSM) in_cyc_q.push_back(cyc);
        if (l == rst_line && p == wd / 2) begin
          rst = 1'b1;
          rst_cyc = cyc + 1;
        end
        tick();
        if (rst) begin
          rst = 1'b0;
          rst_win = 1'b1;
        end
        de_i = 1'b0;
        di_i = 8'd0;
        repeat (per - 1) tick();
      end
      hs_i = 1'b0;
      tick();
      tick();
      tick();
      if (l == 0 && mid_step >= 0) scale_step = 16'(mid_step);
    end
    vs_i = 1'b0;
    repeat (6) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_chk++; if (do_o !== 8'd0) $display("FAIL reset_do: got %0d expected 0", do_o); else n_pass++;
    n_chk++; if (de_o !== 1'b0) $display("FAIL reset_de: got %b expected 0", de_o); else n_pass++;
    n_chk++; if (hs_o !== 1'b0) $display("FAIL reset_hs: got %b expected 0", hs_o); else n_pass++;
    n_chk++; if (vs_o !== 1'b0) $display("FAIL reset_vs: got %b expected 0", vs_o); else n_pass++;
    n_chk++; if (dbg_state_o !== 1'b0) $display("FAIL reset_state: got %b expected IDLE(0)", dbg_state_o); else n_pass++;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_scenarios();
    int exp_nl_c [8] = '{4, 4, 4, 2, 3, 4, 4, 1};
    int spot_c [8][4] = '{'{10, 20, 30, 40}, '{10, 20, 30, 40}, '{0, 45, 90, 135}, '{0, 64, -1, -1},
                          '{-1, -1, -1, -1}, '{0, 45, 90, 135}, '{0, 45, 90, 135}, '{-1, -1, -1, -1}};
    int base_v, base_h, nz0, n_obs, n_hs, n_cmp, idx, wv;
    logic [7:0] got;
    for (int id = 0; id < 8 + NRAND; id++) begin
      setup(id);
      build_model();
      in_cyc_q.delete();
      hs_rise_q.delete();
      base_v = obs_val_q.size();
      base_h = obs_hs_q.size();
      nz0 = nz_bad;
      drive_frame(-1);
      n_obs = obs_val_q.size() - base_v;
      n_hs = obs_hs_q.size() - base_h;
      wv = (wd < LSM) ? wd : LSM;

      n_chk++;
      if (n_obs !== exp_q.size()) $display("FAIL s%0d_pixel_count: got %0d expected %0d", id, n_obs, exp_q.size());
      else n_pass++;
      n_cmp = (n_obs < exp_q.size()) ? n_obs : exp_q.size();
      for (int i = 0; i < n_cmp; i++) begin
        n_chk++;
        if (obs_val_q[base_v + i] !== exp_q[i])
          $display("FAIL s%0d_pixel[%0d]: got %0d expected %0d", id, i, obs_val_q[base_v + i], exp_q[i]);
        else n_pass++;
        n_chk++;
        if (obs_cyc_q[base_v + i] !== in_cyc_q[i] + 3)
          $display("FAIL s%0d_latency[%0d]: got cycle %0d expected %0d", id, i, obs_cyc_q[base_v + i], in_cyc_q[i] + 3);
        else n_pass++;
      end

      n_chk++;
      if (n_hs !== hs_rise_q.size()) $display("FAIL s%0d_hs_lines: got %0d expected %0d", id, n_hs, hs_rise_q.size());
      else n_pass++;
      for (int i = 0; i < n_hs && i < hs_rise_q.size(); i++) begin
        n_chk++;
        if (obs_hs_q[base_h + i] !== hs_rise_q[i] + 3)
          $display("FAIL s%0d_hs_rise[%0d]: got cycle %0d expected %0d", id, i, obs_hs_q[base_h + i], hs_rise_q[i] + 3);
        else n_pass++;
      end

      n_chk++;
      if (vs_rise_out !== vs_rise_in + 3) $display("FAIL s%0d_vs_delay: got cycle %0d expected %0d", id, vs_rise_out, vs_rise_in + 3);
      else n_pass++;
      n_chk++;
      if (nz_bad !== nz0) $display("FAIL s%0d_do_idle_zero: got %0d nonzero idle samples expected 0", id, nz_bad - nz0);
      else n_pass++;

      if (id < 8) begin
        n_chk++;
        if (n_hs !== exp_nl_c[id]) $display("FAIL s%0d_line_count: got %0d expected %0d", id, n_hs, exp_nl_c[id]);
        else n_pass++;
        for (int l = 0; l < 4; l++) begin
          if (spot_c[id][l] >= 0) begin
            idx = base_v + l * wv;
            got = (idx < obs_val_q.size()) ? obs_val_q[idx] : 8'hxx;
            n_chk++;
            if (got !== 8'(spot_c[id][l])) $display("FAIL s%0d_line%0d_value: got %0d expected %0d", id, l, got, spot_c[id][l]);
            else n_pass++;
          end
        end
      end
      if (id == 4) begin
        for (int l = 0; l < 3; l++) for (int x = 0; x < wd; x++) begin
          idx = base_v + l * wd + x;
          got = (idx < obs_val_q.size()) ? obs_val_q[idx] : 8'hxx;
          n_chk++;
          if (got !== pix[2 * l][x]) $display("FAIL s4_passthru[%0d][%0d]: got %0d expected %0d", l, x, got, pix[2 * l][x]);
          else n_pass++;
        end
      end
      if (id == 7) begin
        n_chk++;
        if (n_obs !== LSM) $display("FAIL s7_overflow_count: got %0d expected %0d", n_obs, LSM);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base_v, bad0, late, n_obs;
    logic [7:0] want;
    setup(2);
    build_model();
    in_cyc_q.delete();
    hs_rise_q.delete();
    base_v = obs_val_q.size();
    bad0 = post_rst_bad;
    drive_frame(2);
    rst_win = 1'b0;
    n_chk++;
    if (post_rst_bad !== bad0) $display("FAIL rstmid_outputs_zero: got %0d active samples expected 0", post_rst_bad - bad0);
    else n_pass++;
    late = 0;
    for (int i = base_v; i < obs_cyc_q.size(); i++) if (obs_cyc_q[i] > rst_cyc) late++;
    n_chk++;
    if (late !== 0) $display("FAIL rstmid_no_de: got %0d de_o pulses after reset expected 0", late);
    else n_pass++;

    // the next frame must be unaffected
    setup(2);
    build_model();
    in_cyc_q.delete();
    hs_rise_q.delete();
    base_v = obs_val_q.size();
    drive_frame(-1);
    n_obs = obs_val_q.size() - base_v;
    n_chk++;
    if (n_obs !== 32) $display("FAIL rstmid_frame2_count: got %0d expected 32", n_obs);
    else n_pass++;
    for (int i = 0; i < 32 && i < n_obs; i++) begin
      want = 8'(45 * (i / 8));
      n_chk++;
      if (obs_val_q[base_v + i] !== want) $display("FAIL rstmid_frame2[%0d]: got %0d expected %0d", i, obs_val_q[base_v + i], want);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_reset_midframe();
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scaler_v.md
Name: scaler_v

Overview:
- Vertical downscaler that sits directly downstream of scaler_h and consumes its de/hs/vs pixel stream.
- Holds one previous input line in a block-RAM line buffer.
- Produces output lines by linear interpolation between the previous and current input lines, at vertical positions stepped by a 4.12 fixed-point scale factor.
- Downscale-only: at most one output line per input line, so it streams with no output-rate decoupling.

Parameters:
- LINE_SIZE_MAX, 4096: maximum pixels per line; sets line-buffer depth.
- DATA_WIDTH, 8: pixel width, unsigned.
- PIXEL_STEP, 4096: fixed-point value of 1.0 (12 fractional bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- scale_step  in  16  unsigned 4.12 vertical step in input lines per output line; sampled at frame start
- di_i  in  DATA_WIDTH  input pixel
- de_i  in  1  input pixel valid
- hs_i  in  1  high while an input line is active
- vs_i  in  1  high while an input frame is active
- do_o  out  DATA_WIDTH  output pixel
- de_o  out  1  output pixel valid
- hs_o  out  1  high while an emitted output line is active
- vs_o  out  1  frame-active, delayed copy of vs_i

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Line counter n, position accumulator pos (28 bits: 16 integer, 12 fractional) and pixel counter x are all 0.
- States:
  - IDLE → FRAME on a vs_i rising edge (0→1 between consecutive cycles).
  - FRAME → IDLE on a vs_i falling edge.
  - rst from any state → IDLE. A reset mid-frame discards the remainder of that frame; output resumes only after the next vs_i rising edge.
- Frame start (on entering FRAME):
  - n=0, pos=0.
  - step_r = max(scale_step, PIXEL_STEP). Values below 4096 are clamped to unity because upscale is unsupported.
- Per input line:
  - x resets on the hs_i rising edge and increments on each de_i.
  - n increments on each hs_i falling edge.
  - Let I = pos[27:12] and f = pos[11:0].
  - The line is emitted when either (f==0 and I==n) or (f!=0 and I==n-1). By construction at most one emission per line, since step_r ≥ 1.0.
  - At the falling edge of an emitted line, pos += step_r. The accumulator saturates at its maximum; it never wraps.
- Line buffer:
  - One RAM of LINE_SIZE_MAX x DATA_WIDTH.
  - Each valid pixel reads address x (the previous line, prev) and writes di_i at x in the same cycle, read-before-write.
  - The buffer is written on every line, emitted or not.
- Arithmetic on emitted lines:
  - f==0: do_o = cur.
  - otherwise: do_o = (prev*(4096-f) + cur*f + 2048) >> 12.
  - The intermediate is DATA_WIDTH+13 bits; the result fits DATA_WIDTH with no saturation needed.
- Latency:
  - Fixed 3 clk from di_i/de_i to do_o/de_o, independent of de_i gaps (any de_i duty cycle).
  - vs_o is vs_i delayed 3 clk.
  - hs_o is hs_i delayed 3 clk, gated by the emit flag. It stays 0 for skipped lines.
  - de_o is de_i delayed 3 clk, gated by emit and by x<LINE_SIZE_MAX.
  - do_o is 0 whenever de_o is 0.
- Boundaries:
  - Pixels with x ≥ LINE_SIZE_MAX are neither written nor output; x saturates.
  - In line 0, prev is don't-care because emission requires f==0 there.
  - The final input line is never used as prev; a position falling after it is dropped.
  - A scale_step change mid-frame takes effect at the next frame.
  - de_i outside hs_i is ignored.

Test Plan:
1. step=4096; 4 lines of width 8 with constant values 10, 20, 30, 40 → 4 output lines of 8 pixels each: 10, 20, 30, 40. de_o lags de_i by exactly 3 clk.
2. step=6144 (1.5); 6 lines with values 0, 30, 60, 90, 120, 150 → 4 output lines: 0, 45, 90, 135. hs_o stays 0 during input lines 1 and 4.
3. step=5120 (1.25); line1 all 0, line2 all 255 → second output line (emitted with input line 2) = 64 (rounding check: 263168>>12).
4. step=2048 → clamped; output identical to scenario 1. step=8192 on 5 lines → input lines 0, 2, 4 passed through unchanged.
5. DE_I_PERIOD=2 and 4 (gapped de_i) with scenario-2 data → identical pixel values and count; per-pixel latency stays 3 clk.
6. rst pulsed mid-line of frame 1 → all outputs 0 from the next cycle and no de_o until the next vs_i rising edge. Frame 2 output then matches scenario 2 exactly. A line of LINE_SIZE_MAX+2 pixels yields LINE_SIZE_MAX de_o pulses.
